// File: rtl/gpio_access_controller.sv
// GPIO bank access sequencer: turns CPU register requests into one-cycle bank strobes,
// keeps direction/output shadows, and polls the input pins for sticky change flags.
module gpio_access_controller #(
    parameter int NUM_PINS    = 13,
    parameter int BUS_WIDTH   = 64,
    parameter int POLL_PERIOD = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_addr,
    input  logic [BUS_WIDTH-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [BUS_WIDTH-1:0] rsp_rdata,
    output logic [BUS_WIDTH-1:0] bus_out,
    output logic                 bus_oe,
    input  logic [BUS_WIDTH-1:0] bus_in,
    output logic                 load_dir,
    output logic                 load_out,
    output logic                 read_in,
    output logic                 irq,
    output logic [1:0]           dbg_state
);

    // Handshakes: a request transfers on a cycle where req_valid && req_ready;
    // a response transfers on a cycle where rsp_valid && rsp_ready. Both valids
    // hold their payload stable until the transfer.

    localparam int CW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [CW-1:0] POLL_RELOAD = (POLL_PERIOD > 0) ? CW'(POLL_PERIOD - 1) : '0;

    localparam logic [1:0] A_DIR = 2'd0;
    localparam logic [1:0] A_OUT = 2'd1;
    localparam logic [1:0] A_IN  = 2'd2;
    localparam logic [1:0] A_CHG = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        SAMPLE = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [1:0]            r_addr;
    logic [NUM_PINS-1:0]   r_wdata;
    logic                  r_poll_cmd;
    logic [NUM_PINS-1:0]   r_dir;
    logic [NUM_PINS-1:0]   r_out;
    logic [NUM_PINS-1:0]   r_last;
    logic [NUM_PINS-1:0]   r_chg;
    logic                  r_pin_valid;
    logic [BUS_WIDTH-1:0]  r_rdata;
    logic                  r_irq;
    logic [CW-1:0]         r_poll_cnt;
    logic                  r_poll_pending;

    logic                  w_accept;
    logic                  w_take_poll;
    logic                  w_tick;
    logic [NUM_PINS-1:0]   w_sample;
    logic [NUM_PINS-1:0]   w_chg_set;
    logic [NUM_PINS-1:0]   w_chg_clr;
    logic                  w_unused;

    assign w_sample  = bus_in[NUM_PINS-1:0];
    assign w_tick    = (POLL_PERIOD > 0) && (r_poll_cnt == '0);
    assign irq       = r_irq;
    assign dbg_state = r_state;
    assign w_unused  = ^{req_wdata, bus_in};

    // Output pins (dir bit 1) never raise a change flag.
    assign w_chg_set = (r_state == SAMPLE && r_pin_valid) ? ((w_sample ^ r_last) & ~r_dir) : '0;
    assign w_chg_clr = (w_accept && req_write && req_addr == A_CHG) ? req_wdata[NUM_PINS-1:0] : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_take_poll = 1'b0;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_rdata   = '0;
        bus_out     = '0;
        bus_oe      = 1'b0;
        load_dir    = 1'b0;
        load_out    = 1'b0;
        read_in     = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_poll_pending) begin
                    w_take_poll = 1'b1;
                    w_state_nxt = SAMPLE;
                end else begin
                    req_ready = !reset;
                    if (req_valid && !reset) begin
                        w_accept = 1'b1;
                        if (req_write) begin
                            w_state_nxt = (req_addr == A_DIR || req_addr == A_OUT) ? WRITE : RESP;
                        end else begin
                            w_state_nxt = (req_addr == A_IN) ? SAMPLE : RESP;
                        end
                    end
                end
            end
            WRITE: begin
                bus_oe      = 1'b1;
                bus_out     = BUS_WIDTH'(r_wdata);
                load_dir    = (r_addr == A_DIR);
                load_out    = (r_addr == A_OUT);
                w_state_nxt = RESP;
            end
            SAMPLE: begin
                read_in     = 1'b1;
                w_state_nxt = r_poll_cmd ? IDLE : RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = r_rdata;
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= IDLE;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_poll_cmd     <= 1'b0;
            r_dir          <= '0;
            r_out          <= '0;
            r_last         <= '0;
            r_chg          <= '0;
            r_pin_valid    <= 1'b0;
            r_rdata        <= '0;
            r_irq          <= 1'b0;
            r_poll_cnt     <= POLL_RELOAD;
            r_poll_pending <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_chg   <= (r_chg & ~w_chg_clr) | w_chg_set;
            r_irq   <= |r_chg;

            if (w_accept) begin
                r_addr     <= req_addr;
                r_wdata    <= req_wdata[NUM_PINS-1:0];
                r_poll_cmd <= 1'b0;
                if (req_write) begin
                    r_rdata <= '0;
                end else begin
                    case (req_addr)
                        A_DIR:   r_rdata <= BUS_WIDTH'(r_dir);
                        A_OUT:   r_rdata <= BUS_WIDTH'(r_out);
                        A_CHG:   r_rdata <= BUS_WIDTH'(r_chg);
                        default: r_rdata <= '0;
                    endcase
                end
            end
            if (w_take_poll) begin
                r_poll_cmd <= 1'b1;
            end

            if (r_state == WRITE) begin
                if (r_addr == A_DIR) r_dir <= r_wdata;
                if (r_addr == A_OUT) r_out <= r_wdata;
            end

            if (r_state == SAMPLE) begin
                r_last      <= w_sample;
                r_pin_valid <= 1'b1;
                if (!r_poll_cmd) begin
                    r_rdata <= BUS_WIDTH'(w_sample);
                end
            end

            // A tick landing while a poll is already pending is simply absorbed.
            if (POLL_PERIOD > 0) begin
                r_poll_cnt <= w_tick ? POLL_RELOAD : (r_poll_cnt - 1'b1);
            end
            r_poll_pending <= w_tick | (r_poll_pending & ~w_take_poll);
        end
    end

endmodule

// File: tb/tb_gpio_access_controller.sv
// Directed bench for gpio_access_controller: register access latency, masking,
// response back-pressure, polling change flags/irq, poll priority and mid-write reset.
module tb_gpio_access_controller;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic [63:0] bus_out;
    logic        bus_oe;
    logic [63:0] bus_in;
    logic        load_dir;
    logic        load_out;
    logic        read_in;
    logic        irq;
    logic [1:0]  dbg_state;

    int n_vec  = 0;
    int n_miss = 0;
    logic [63:0] exp_q[$];

    gpio_access_controller #(
        .NUM_PINS(13), .BUS_WIDTH(64), .POLL_PERIOD(16)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in),
        .load_dir(load_dir), .load_out(load_out), .read_in(read_in),
        .irq(irq), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request at a negedge, wait (bounded) for req_ready, and return at the
    // negedge of the cycle after acceptance (T+1).
    task automatic issue(input logic wr, input logic [1:0] addr, input logic [63:0] wd);
        int waited;
        waited    = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        #1;
        while (!req_ready && waited < 40) begin
            @(negedge clock);
            #1;
            waited++;
        end
        chk("req_accept", {63'b0, req_ready}, 64'd1);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    // Wait (bounded) for the response, compare against the scoreboard, complete the handshake.
    task automatic finish_rsp(input string tag);
        int waited;
        logic [63:0] exp;
        waited = 0;
        while (!rsp_valid && waited < 40) begin
            @(negedge clock);
            waited++;
        end
        chk({tag, "_rsp_valid"}, {63'b0, rsp_valid}, 64'd1);
        exp = exp_q.pop_front();
        chk({tag, "_rdata"}, rsp_rdata, exp);
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp_ready = 1'b0;
    endtask

    task automatic wait_poll();
        int waited;
        waited = 0;
        while (!read_in && waited < 40) begin
            @(negedge clock);
            waited++;
        end
        chk("poll_seen", {63'b0, read_in}, 64'd1);
    endtask

    initial begin
        bit seen_rsp;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 2'd0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        bus_in    = '0;

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_state", {62'b0, dbg_state}, 64'd0);
        chk("rst_outs", {58'b0, req_ready, rsp_valid, bus_oe, load_dir, load_out, read_in}, 64'd0);
        chk("rst_irq", {63'b0, irq}, 64'd0);
        chk("rst_buses", rsp_rdata | bus_out, 64'd0);
        reset = 1'b0;

        // Write DIR 0x00F0: strobe at T+1, response at T+2
        issue(1'b1, 2'd0, 64'h00F0);
        chk("wdir_load_dir", {63'b0, load_dir}, 64'd1);
        chk("wdir_bus_oe", {63'b0, bus_oe}, 64'd1);
        chk("wdir_bus_out", bus_out, 64'h00F0);
        chk("wdir_other", {60'b0, load_out, read_in, rsp_valid, 1'b0}, 64'd0);
        @(negedge clock);
        chk("wdir_t2_valid", {63'b0, rsp_valid}, 64'd1);
        chk("wdir_t2_strobe", {62'b0, load_dir, bus_oe}, 64'd0);
        exp_q.push_back(64'h0);
        finish_rsp("wdir");

        // Read DIR: response at T+1, no strobe
        issue(1'b0, 2'd0, 64'h0);
        chk("rdir_t1_valid", {63'b0, rsp_valid}, 64'd1);
        chk("rdir_no_strobe", {60'b0, load_dir, load_out, read_in, bus_oe}, 64'd0);
        exp_q.push_back(64'h00F0);
        finish_rsp("rdir");

        // Write OUT all ones: upper bits masked on the bus and in the shadow
        issue(1'b1, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("wout_load_out", {63'b0, load_out}, 64'd1);
        chk("wout_load_dir", {63'b0, load_dir}, 64'd0);
        chk("wout_bus_out", bus_out, 64'h1FFF);
        exp_q.push_back(64'h0);
        finish_rsp("wout");
        issue(1'b0, 2'd1, 64'h0);
        exp_q.push_back(64'h1FFF);
        finish_rsp("rout");

        // DIR = 0, read IN with back-pressure on the response
        issue(1'b1, 2'd0, 64'h0);
        exp_q.push_back(64'h0);
        finish_rsp("wdir0");
        bus_in = 64'h0005;
        issue(1'b0, 2'd2, 64'h0);
        chk("rin_read_in", {63'b0, read_in}, 64'd1);
        chk("rin_bus_oe", {63'b0, bus_oe}, 64'd0);
        @(negedge clock);
        chk("rin_t2_valid", {63'b0, rsp_valid}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("rin_hold_valid", {63'b0, rsp_valid}, 64'd1);
            chk("rin_hold_data", rsp_rdata, 64'h0005);
            chk("rin_hold_ready", {63'b0, req_ready}, 64'd0);
        end
        exp_q.push_back(64'h0005);
        finish_rsp("rin");

        // Establish a zero baseline, make pin 1 an output, clear stale flags
        bus_in = 64'h0;
        wait_poll();
        @(negedge clock);
        issue(1'b1, 2'd0, 64'h0002);
        exp_q.push_back(64'h0);
        finish_rsp("wdir2");
        issue(1'b1, 2'd3, 64'h1FFF);
        exp_q.push_back(64'h0);
        finish_rsp("wchg_all");
        issue(1'b0, 2'd3, 64'h0);
        exp_q.push_back(64'h0);
        finish_rsp("rchg0");
        chk("irq_cleared", {63'b0, irq}, 64'd0);

        // Pins 0 and 1 go high; only input pin 0 flags, irq one cycle after the flag
        bus_in = 64'h0003;
        wait_poll();
        @(negedge clock);
        chk("irq_lag", {63'b0, irq}, 64'd0);
        @(negedge clock);
        chk("irq_set", {63'b0, irq}, 64'd1);
        issue(1'b0, 2'd3, 64'h0);
        exp_q.push_back(64'h0001);
        finish_rsp("rchg1");
        issue(1'b1, 2'd3, 64'h0001);
        chk("wchg_irq_t1", {63'b0, irq}, 64'd1);
        exp_q.push_back(64'h0);
        finish_rsp("wchg1");
        chk("wchg_irq_t2", {63'b0, irq}, 64'd0);

        // Poll beats a simultaneous CPU request
        wait_poll();
        repeat (15) @(negedge clock);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 2'd0;
        #1;
        chk("prio_ready_lo", {63'b0, req_ready}, 64'd0);
        @(negedge clock);
        chk("prio_poll_first", {63'b0, read_in}, 64'd1);
        chk("prio_ready_lo2", {63'b0, req_ready}, 64'd0);
        @(negedge clock);
        chk("prio_ready_hi", {63'b0, req_ready}, 64'd1);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        chk("prio_rsp_t1", {63'b0, rsp_valid}, 64'd1);
        exp_q.push_back(64'h0002);
        finish_rsp("prio");

        // Reset during a write of OUT: transaction dropped, shadow stays at reset value
        issue(1'b1, 2'd1, 64'h0AAA);
        chk("rstw_in_write", {63'b0, load_out}, 64'd1);
        reset = 1'b1;
        @(negedge clock);
        chk("rstw_outs", {58'b0, req_ready, rsp_valid, bus_oe, load_dir, load_out, read_in}, 64'd0);
        chk("rstw_buses", rsp_rdata | bus_out, 64'd0);
        reset    = 1'b0;
        seen_rsp = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (rsp_valid) seen_rsp = 1'b1;
        end
        chk("rstw_no_rsp", {63'b0, seen_rsp}, 64'd0);
        issue(1'b0, 2'd1, 64'h0);
        exp_q.push_back(64'h0);
        finish_rsp("rstw_rout");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/gpio_access_controller.md
Name: gpio_access_controller

Overview:
- Sequences the 13-pin GPIO peripheral bank: turns single CPU register requests into one-cycle load_dir / load_out / read_in strobes and drives or samples the shared 64-bit peripheral data bus.
- Keeps shadow copies of the direction and output registers.
- Periodically polls the input pins, latches sticky pin-change flags on input-direction pins and raises irq.
- Sits between the CPU memory-mapped request port and the GPIO bank; the bus tri-state is resolved one level up.

Parameters:
- NUM_PINS, 13, number of GPIO pins; valid range 1..BUS_WIDTH.
- BUS_WIDTH, 64, data bus width.
- POLL_PERIOD, 16, cycles between automatic input samples; 0 disables polling.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  controller accepts a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  2  register select: 0 DIR, 1 OUT, 2 IN, 3 CHG.
- req_wdata  in  BUS_WIDTH  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  CPU accepts the response.
- rsp_rdata  out  BUS_WIDTH  read data; 0 for write acks.
- bus_out  out  BUS_WIDTH  value driven onto the peripheral bus.
- bus_oe  out  1  controller drives the bus.
- bus_in  in  BUS_WIDTH  sampled peripheral bus.
- load_dir  out  1  direction-load strobe (LOAD_DIR).
- load_out  out  1  output-load strobe (LOAD_OUT).
- read_in  out  1  input-read strobe (READ_IN).
- irq  out  1  registered OR of the change flags.

Behaviour:
- Reset, synchronous: state IDLE. All outputs, dir_shadow, out_shadow, pin_last, chg_flags and pin_valid are 0. poll_cnt = POLL_PERIOD-1; poll_pending = 0.
- Reset mid-operation: any strobe, bus_oe or rsp_valid deasserts on the cycle after reset is sampled. The in-flight transaction is dropped with no response.
- States: IDLE, WRITE, SAMPLE, RESP.
- IDLE:
  - If poll_pending, go to SAMPLE (poll), clear poll_pending, req_ready = 0. A poll always beats a CPU request.
  - Otherwise req_ready = 1. A request is accepted when req_valid & req_ready, and req_* is latched.
- Accepted write to addr 0 or 1: go to WRITE.
- Accepted write to addr 3: chg_flags &= ~req_wdata[NUM_PINS-1:0]; go to RESP.
- Accepted write to addr 2: ignored; go to RESP with an ack.
- Accepted read of addr 0, 1 or 3: go to RESP with zero-extended dir_shadow, out_shadow or chg_flags respectively.
- Accepted read of addr 2: go to SAMPLE (cpu).
- WRITE, exactly 1 cycle:
  - bus_oe = 1; bus_out = wdata with bits at NUM_PINS and above forced to 0.
  - load_dir = 1 for addr 0, load_out = 1 for addr 1.
  - The matching shadow register updates at the end of the cycle; then go to RESP.
- SAMPLE, exactly 1 cycle:
  - read_in = 1, bus_oe = 0.
  - At the clock edge capture s = bus_in[NUM_PINS-1:0].
  - If pin_valid: chg_flags |= (s ^ pin_last) & ~dir_shadow. A dir bit of 1 means output, so output pins never flag.
  - Then pin_last = s and pin_valid = 1.
  - Poll sample: return to IDLE. CPU sample: go to RESP with zero-extended s.
- Invariants: bus_oe and read_in are never high in the same cycle. At most one strobe is high per cycle. Every bus access is followed by at least one non-bus cycle (RESP or IDLE).
- RESP: rsp_valid = 1 and rsp_rdata held stable until rsp_ready; go to IDLE on the cycle after the handshake.
- Latency from accept cycle T: shadow or CHG access has rsp_valid at T+1. WRITE or IN access has the strobe at T+1 and rsp_valid at T+2.
- Poll timer:
  - Decrements every cycle, including during transactions.
  - At 0 it sets poll_pending and reloads POLL_PERIOD-1.
  - If poll_pending is already set, the extra tick is lost; no backlog is kept.
  - POLL_PERIOD = 0: the timer is held and poll_pending is never set.
- Simultaneous events: a change flag being set and a CHG write-1-to-clear in the same cycle resolve set-wins.
- irq: registered; irq = |chg_flags, one cycle after the flags update.

Test Plan:
- Reset, then write addr 0 wdata 0x00F0 -> load_dir high exactly one cycle at T+1 with bus_oe=1 and bus_out=0x00F0; rsp_valid at T+2; read addr 0 returns 0x00F0 at T+1 with no strobe.
- Write addr 1 wdata 0xFFFF_FFFF_FFFF_FFFF -> bus_out = 0x1FFF (upper bits masked); load_out pulse; readback of OUT = 0x1FFF.
- DIR = 0; bus_in = 0x0005; read addr 2 -> read_in pulse with bus_oe=0; rsp_rdata = 0x0005 at T+2. rsp_ready held low 3 cycles -> rsp_valid and data stable, req_ready stays 0.
- POLL_PERIOD=16, DIR = 0x0002. bus_in 0x0000 at the first poll, then 0x0003 -> after the second poll chg_flags = 0x0001 (pin 1 masked as output), irq = 1 next cycle. Write addr 3 wdata 0x0001 -> flags = 0, irq drops.
- poll_pending and req_valid both present in IDLE -> poll SAMPLE first with req_ready = 0; CPU request accepted on the following IDLE cycle.
- Reset asserted during WRITE of addr 1 -> no rsp_valid ever issued; out_shadow = 0; all outputs 0 on the next cycle.
